dot_product_acc: RTL and testbench

- Sequential dot-product stage wrapped around the combinational unsigned array multiplier.
- Streams operand pairs in with a valid/ready handshake and registers each pair onto the multiplier's a/b inputs.
- Consumes the multiplier's product and accumulates over one vector; emits the sum with a valid/ready handshake.
- Downstream consumers are vector-level blocks (scaling, result FIFO).

---
 rtl/dot_product_pkg.sv | 23 ++
 rtl/dot_product_acc.sv | 124 ++++++++++++
 tb/tb_dot_product_acc.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_pkg.sv
// dot_product_pkg: shared helpers for the dot_product_acc block.
//   acc_width(n, max_len) - accumulator/result width that cannot overflow
//                           for max_len products of two n-bit operands
//   cnt_width(max_len)    - element counter width able to hold max_len
//   stage1_flags_t        - control half of the stage-1 register; the
//                           operand half depends on N and is declared in
//                           the block that knows N
package dot_product_pkg;

  function automatic int acc_width(input int n, input int max_len);
    return 2 * n + $clog2(max_len);
  endfunction

  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  typedef struct packed {
    logic last;
    logic valid;
  } stage1_flags_t;

endpackage

// File: rtl/dot_product_acc.sv
// dot_product_acc: streaming dot-product stage around an external
// combinational multiplier.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     operand pair handshake
//   in_a, in_b, in_last   unsigned elements, last marks the final element
//   mul_a, mul_b          registered operands driven to the multiplier
//   mul_p                 multiplier product (combinational from mul_a/mul_b)
//   out_valid/out_ready   result handshake
//   out_sum, out_count    dot product and number of elements in the vector
//   out_len_err           vector was cut at MAX_LEN without in_last
//
// Optional feature (macro DOT_PRODUCT_ACC_STATS_EN):
//   stat_vectors [15:0]   retired results, wraps
//   stat_len_errs [7:0]   retired results flagged out_len_err, saturates
module dot_product_acc
  import dot_product_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int MAX_LEN = 16,
  localparam int CNT_W   = cnt_width(MAX_LEN),
  localparam int ACC_W   = acc_width(N, MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic [2*N-1:0]   mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_len_err
`ifdef DOT_PRODUCT_ACC_STATS_EN
  ,
  output logic [15:0]      stat_vectors,
  output logic [7:0]       stat_len_errs
`endif
);

  typedef struct packed {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    stage1_flags_t flags;
  } stage1_t;

  stage1_t          s1;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             terminal;
  logic             stall;

  assign mul_a    = s1.a;
  assign mul_b    = s1.b;
  assign in_ready = ~stall;

  // A result that has not been taken freezes the whole pipe, so no element
  // can be accumulated into a result register that is still on display.
  always_comb begin
    stall    = out_valid & ~out_ready;
    acc_sum  = acc + ACC_W'(mul_p);
    cnt_inc  = cnt + CNT_W'(1);
    terminal = s1.flags.valid & (s1.flags.last | (cnt_inc == CNT_W'(MAX_LEN)));
  end

  // Stage 1 captures the accepted pair; the product of the pair in stage 1
  // is folded into the accumulator on the following unstalled edge. A
  // terminal element publishes the running sum and restarts the vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1          <= '0;
      acc         <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_count   <= '0;
      out_len_err <= 1'b0;
    end else if (!stall) begin
      s1.flags.valid <= in_valid;
      if (in_valid) begin
        s1.a          <= in_a;
        s1.b          <= in_b;
        s1.flags.last <= in_last;
      end
      out_valid <= terminal;
      if (terminal) begin
        out_sum     <= acc_sum;
        out_count   <= cnt_inc;
        out_len_err <= ~s1.flags.last;
        acc         <= '0;
        cnt         <= '0;
      end else if (s1.flags.valid) begin
        acc <= acc_sum;
        cnt <= cnt_inc;
      end
    end
  end

`ifdef DOT_PRODUCT_ACC_STATS_EN
  logic retire;
  assign retire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_vectors  <= '0;
      stat_len_errs <= '0;
    end else if (retire) begin
      stat_vectors <= stat_vectors + 16'd1;
      if (out_len_err && (stat_len_errs != 8'hFF)) begin
        stat_len_errs <= stat_len_errs + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dot_product_acc.sv
// tb_dot_product_acc: self-checking bench for dot_product_acc.
// A behavioural multiplier drives mul_p from mul_a/mul_b. A table of
// hand-computed vectors covers the corner cases, followed by stall, reset
// and randomized traffic checked against a queue-based reference model.
// Stats ports are checked when DOT_PRODUCT_ACC_STATS_EN is defined.
module tb_dot_product_acc;

  localparam int N       = 8;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 5;
  localparam int ACC_W   = 20;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             in_last;
  logic [N-1:0]     mul_a;
  logic [N-1:0]     mul_b;
  logic [2*N-1:0]   mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_len_err;
`ifdef DOT_PRODUCT_ACC_STATS_EN
  logic [15:0]      stat_vectors;
  logic [7:0]       stat_len_errs;
`endif

  dot_product_acc #(.N(N), .MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_last     (in_last),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_p       (mul_p),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_count   (out_count),
    .out_len_err (out_len_err)
`ifdef DOT_PRODUCT_ACC_STATS_EN
    ,
    .stat_vectors  (stat_vectors),
    .stat_len_errs (stat_len_errs)
`endif
  );

  // Stand-in for the external combinational array multiplier.
  assign mul_p = 16'(mul_a) * 16'(mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic             err;
  } res_t;

  typedef struct packed {
    logic [16:0][7:0] a;
    logic [16:0][7:0] b;
    logic [4:0]       len;
    logic             last_on_final;
    logic             chk_lat;
    logic [ACC_W-1:0] exp_sum;
    logic [CNT_W-1:0] exp_count;
    logic             exp_err;
  } rec_t;

  res_t        exp_q[$];
  res_t        ret_q[$];
  res_t        mon_e;
  int unsigned part_sum = 0;
  int          part_cnt = 0;
  int          model_vectors = 0;
  int          model_errs = 0;
  bit          rand_ready = 1'b0;
  rec_t        tbl[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    n_vec++;
    n_err++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic last);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) failNow("accept");
  endtask

  task automatic waitRetired(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (ret_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) failNow("retire");
  endtask

  // Reference model: tracks accepted pairs per vector with plain arithmetic,
  // queues the result each vector should produce, and checks every
  // displayed result against the oldest outstanding one.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      part_sum      = 0;
      part_cnt      = 0;
      model_vectors = 0;
      model_errs    = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("mon_unexpected", 32'(out_valid), 32'd0);
        end else begin
          mon_e = exp_q[0];
          checkOutput("mon_sum", 32'(out_sum), 32'(mon_e.sum));
          checkOutput("mon_count", 32'(out_count), 32'(mon_e.count));
          checkOutput("mon_len_err", 32'(out_len_err), 32'(mon_e.err));
          if (out_ready) begin
            void'(exp_q.pop_front());
            ret_q.push_back('{sum: out_sum, count: out_count, err: out_len_err});
            model_vectors = (model_vectors + 1) % 65536;
            if (mon_e.err && model_errs < 255) model_errs++;
          end
        end
      end
      if (in_valid && in_ready) begin
        part_sum += int'(in_a) * int'(in_b);
        part_cnt++;
        if (in_last || part_cnt == MAX_LEN) begin
          exp_q.push_back('{sum: ACC_W'(part_sum), count: CNT_W'(part_cnt), err: !in_last});
          part_sum = 0;
          part_cnt = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int len;
    bit use_last;

    // Hand-computed vector table.
    for (int r = 0; r < 8; r++) tbl[r] = '0;
    tbl[0].len = 4; tbl[0].last_on_final = 1; tbl[0].chk_lat = 1;
    for (int k = 0; k < 4; k++) begin
      tbl[0].a[k] = 8'(k + 1);
      tbl[0].b[k] = 8'(k + 5);
    end
    tbl[0].exp_sum = 70; tbl[0].exp_count = 4; tbl[0].exp_err = 0;
    tbl[1].len = 1; tbl[1].last_on_final = 1; tbl[1].chk_lat = 1;
    tbl[1].a[0] = 255; tbl[1].b[0] = 255;
    tbl[1].exp_sum = 65025; tbl[1].exp_count = 1; tbl[1].exp_err = 0;
    tbl[2].len = 16; tbl[2].last_on_final = 1; tbl[2].chk_lat = 1;
    for (int k = 0; k < 16; k++) begin
      tbl[2].a[k] = 255;
      tbl[2].b[k] = 255;
    end
    tbl[2].exp_sum = 1040400; tbl[2].exp_count = 16; tbl[2].exp_err = 0;
    tbl[3].len = 17; tbl[3].last_on_final = 0; tbl[3].chk_lat = 0;
    for (int k = 0; k < 17; k++) begin
      tbl[3].a[k] = 1;
      tbl[3].b[k] = 1;
    end
    tbl[3].exp_sum = 16; tbl[3].exp_count = 16; tbl[3].exp_err = 1;
    tbl[4].len = 1; tbl[4].last_on_final = 1; tbl[4].chk_lat = 1;
    tbl[4].a[0] = 2; tbl[4].b[0] = 3;
    tbl[4].exp_sum = 7; tbl[4].exp_count = 2; tbl[4].exp_err = 0;
    tbl[5].len = 16; tbl[5].last_on_final = 0; tbl[5].chk_lat = 1;
    for (int k = 0; k < 16; k++) begin
      tbl[5].a[k] = 1;
      tbl[5].b[k] = 1;
    end
    tbl[5].exp_sum = 16; tbl[5].exp_count = 16; tbl[5].exp_err = 1;
    tbl[6].len = 3; tbl[6].last_on_final = 1; tbl[6].chk_lat = 1;
    tbl[6].a[0] = 0; tbl[6].a[1] = 5; tbl[6].a[2] = 0;
    tbl[6].b[0] = 9; tbl[6].b[1] = 0; tbl[6].b[2] = 7;
    tbl[6].exp_sum = 0; tbl[6].exp_count = 3; tbl[6].exp_err = 0;
    tbl[7].len = 16; tbl[7].last_on_final = 1; tbl[7].chk_lat = 1;
    for (int k = 0; k < 16; k++) begin
      tbl[7].a[k] = 8'(k + 1);
      tbl[7].b[k] = 1;
    end
    tbl[7].exp_sum = 136; tbl[7].exp_count = 16; tbl[7].exp_err = 0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_sum", 32'(out_sum), 32'd0);
    checkOutput("reset_out_count", 32'(out_count), 32'd0);
    checkOutput("reset_len_err", 32'(out_len_err), 32'd0);
    checkOutput("reset_mul_a", 32'(mul_a), 32'd0);
    checkOutput("reset_mul_b", 32'(mul_b), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int r = 0; r < 8; r++) begin
      ret_q.delete();
      for (int k = 0; k < int'(tbl[r].len); k++) begin
        applyStimulus(tbl[r].a[k], tbl[r].b[k],
                      tbl[r].last_on_final && (k == int'(tbl[r].len) - 1));
      end
      if (tbl[r].chk_lat) begin
        @(negedge clk);
        checkOutput("latency_before", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_after", 32'(out_valid), 32'd1);
      end
      waitRetired(1, ok);
      if (ok) begin
        checkOutput("table_sum", 32'(ret_q[0].sum), 32'(tbl[r].exp_sum));
        checkOutput("table_count", 32'(ret_q[0].count), 32'(tbl[r].exp_count));
        checkOutput("table_len_err", 32'(ret_q[0].err), 32'(tbl[r].exp_err));
      end
    end

    $display("[TB] output stall");
    ret_q.delete();
    out_ready = 1'b0;
    applyStimulus(8'd1, 8'd3, 1'b0);
    applyStimulus(8'd1, 8'd4, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    checkOutput("stall_result_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = 8'd2;
    in_b     = 8'd5;
    in_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_out_sum", 32'(out_sum), 32'd7);
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(8'd2, 8'd5, 1'b0);
    applyStimulus(8'd3, 8'd3, 1'b1);
    waitRetired(2, ok);
    if (ok) begin
      checkOutput("stall_first_sum", 32'(ret_q[0].sum), 32'd7);
      checkOutput("stall_second_sum", 32'(ret_q[1].sum), 32'd19);
      checkOutput("stall_second_count", 32'(ret_q[1].count), 32'd2);
    end

    $display("[TB] reset mid-vector");
    ret_q.delete();
    applyStimulus(8'd1, 8'd1, 1'b0);
    applyStimulus(8'd2, 8'd2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_sum", 32'(out_sum), 32'd0);
    checkOutput("midrst_out_count", 32'(out_count), 32'd0);
    checkOutput("midrst_mul_a", 32'(mul_a), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(8'd2, 8'd3, 1'b0);
    applyStimulus(8'd2, 8'd3, 1'b1);
    waitRetired(1, ok);
    if (ok) begin
      checkOutput("midrst_fresh_sum", 32'(ret_q[0].sum), 32'd12);
      checkOutput("midrst_fresh_count", 32'(ret_q[0].count), 32'd2);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midrst_no_stale", 32'(ret_q.size()), 32'd1);
    end

    $display("[TB] randomized traffic");
    rand_ready = 1'b1;
    for (int v = 0; v < 30; v++) begin
      len      = $urandom_range(1, 18);
      use_last = (len <= MAX_LEN) && ($urandom_range(0, 3) != 0);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
        applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      use_last && (k == len - 1));
      end
    end
    applyStimulus(8'd1, 8'd1, 1'b1);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) failNow("drain");

`ifdef DOT_PRODUCT_ACC_STATS_EN
    @(negedge clk);
    checkOutput("stat_vectors", 32'(stat_vectors), 32'(model_vectors));
    checkOutput("stat_len_errs", 32'(stat_len_errs), 32'(model_errs));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
